// File: rtl/link_pkg.sv
// Frame constants and transmitter state encoding shared by both ends of the byte link.
package link_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/transmit_if.sv
// Parallel request side and serial line of the transmitter.
interface transmit_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data_in;
    logic                 send;
    logic                 data_out;
    logic                 busy;
    logic                 finish;

    modport master (output data_in, send, input data_out, busy, finish);
    modport slave  (input data_in, send, output data_out, busy, finish);
endinterface

// File: rtl/transmit_piso.sv
// Parallel-in serial-out shift register; LSB leaves first.
module piso #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [DATA_BITS-1:0] par_i,
    output logic                 ser_o,
    output logic                 next_o
);
    logic [DATA_BITS-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i)       sr_d = par_i;
        else if (shift_i) sr_d = sr_q >> 1;
    end

    always_ff @(posedge clk) begin
        if (!reset) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign ser_o = sr_q[0];

    // next_o is the bit that becomes ser_o after a shift, so the line register can
    // be loaded with it at the same edge.
    generate
        if (DATA_BITS > 1) begin : g_next
            assign next_o = sr_q[1];
        end else begin : g_next1
            assign next_o = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/transmit.sv
// Asynchronous byte-link transmitter: start bit, DATA_BITS LSB-first, stop bit.
module transmit
    import link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    transmit_if.slave   tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;
    logic          load, shift, ser, ser_next;
    logic          bit_end;

    piso #(.DATA_BITS(DATA_BITS)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .par_i   (tx.data_in),
        .ser_o   (ser),
        .next_o  (ser_next)
    );

    assign bit_end = (cnt_q == CNT_MAX);

    // Outputs are computed for the next state so the line changes on the same
    // edge as the state, keeping every output a plain register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                dout_d = IDLE_LEVEL;
                busy_d = 1'b0;
                if (tx.send) begin
                    state_d = START;
                    load    = 1'b1;
                    dout_d  = START_BIT;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                dout_d = START_BIT;
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dout_d  = ser;
                end
            end
            DATA: begin
                dout_d = ser;
                if (bit_end) begin
                    cnt_d = '0;
                    shift = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                        dout_d  = STOP_BIT;
                    end else begin
                        dout_d  = ser_next;
                    end
                end
            end
            STOP: begin
                dout_d = STOP_BIT;
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dout_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign tx.data_out = dout_q;
    assign tx.busy     = busy_q;
    assign tx.finish   = fin_q;
endmodule

// File: tb/tb_transmit.sv
// Directed plus random frames checked cycle by cycle against a frame-level line model.
module tb_transmit;
    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    transmit_if #(.DATA_BITS(DB)) tif ();

    transmit #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .tx    (tif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s@%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int k);
        chk({tag, "_line"}, k, {7'd0, tif.data_out}, 8'd1);
        chk({tag, "_busy"}, k, {7'd0, tif.busy}, 8'd0);
        chk({tag, "_fin"},  k, {7'd0, tif.finish}, 8'd0);
    endtask

    // Request a frame; returns just after the accepting edge.
    task automatic start(input logic [7:0] d);
        tif.data_in = d;
        tif.send    = 1'b1;
        tick();
        tif.send    = 1'b0;
        tif.data_in = 8'($urandom);
    endtask

    // Checks every cycle of the frame in flight. The line is also sampled at
    // mid-bit like a receiver and the recovered byte compared.
    // ign_k: pulse send with 8'hFF at that cycle; rst_k: reset at that cycle.
    task automatic body(input logic [7:0] d, input int ign_k, input int rst_k, output bit aborted);
        logic [9:0] frame;
        logic [7:0] rx;
        int         b;
        frame   = {1'b1, d, 1'b0};
        rx      = '0;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            if (k == rst_k) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
                chk_idle("rst", k);
                aborted = 1'b1;
                return;
            end
            b = k / CPB;
            chk("line", k, {7'd0, tif.data_out}, {7'd0, frame[b]});
            chk("busy", k, {7'd0, tif.busy}, 8'd1);
            chk("fin",  k, {7'd0, tif.finish}, 8'd0);
            if ((k % CPB) == CPB / 2 && b >= 1 && b <= DB) rx[b-1] = tif.data_out;
            if (k == ign_k) begin
                tif.send    = 1'b1;
                tif.data_in = 8'hFF;
            end
            tick();
            tif.send = 1'b0;
        end
        chk("rx_byte", 0, rx, d);
    endtask

    task automatic tail();
        chk("end_fin",  FRAME, {7'd0, tif.finish}, 8'd1);
        chk("end_busy", FRAME, {7'd0, tif.busy}, 8'd0);
        chk("end_line", FRAME, {7'd0, tif.data_out}, 8'd1);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_idle("idle", i);
        end
    endtask

    task automatic one_frame(input logic [7:0] d, input int ign_k);
        bit ab;
        start(d);
        body(d, ign_k, -1, ab);
        tail();
        quiet(20);
    endtask

    initial begin
        bit ab;
        logic [7:0] r;
        tif.data_in = 8'hA5;
        tif.send    = 1'b1;
        reset       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("reset", i);
        end
        tif.send = 1'b0;
        reset    = 1'b1;
        quiet(3);

        one_frame(8'hA5, -1);
        one_frame(8'h3C, 50);

        // Back-to-back: second request lands in the finish cycle.
        start(8'h01);
        body(8'h01, -1, -1, ab);
        tail();
        tif.data_in = 8'h80;
        tif.send    = 1'b1;
        tick();
        tif.send    = 1'b0;
        body(8'h80, -1, -1, ab);
        tail();
        quiet(20);

        start(8'hC3);
        body(8'hC3, -1, 70, ab);
        chk("abort", 0, {7'd0, ab}, 8'd1);
        quiet(200);
        one_frame(8'h55, -1);

        one_frame(8'h00, -1);
        one_frame(8'hFF, -1);
        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            one_frame(r, (i % 2 == 0) ? int'($urandom_range(FRAME - 1, 0)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
